// File: rtl/timer_pkg.sv
// timer_pkg: shared state and mode encodings for the down-timer channels.
package timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_e;
    typedef enum logic {ONE_SHOT = 1'b0, AUTO_RELOAD = 1'b1} timer_mode_e;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one loadable down-counter with one-shot/auto-reload mode and terminal-count pulse.
module timer_channel
    import timer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] start_val,
    input  logic         mode,
    input  logic         enable,
    input  logic         clear,
    output logic [N-1:0] count,
    output logic         done,
    output logic         tc
);
    timer_state_e state, state_n;
    timer_mode_e  mode_r, mode_n;
    logic [N-1:0] reload_r, reload_n, count_n;
    logic         tc_n, term;

    assign term = (state == RUN) && enable && (count == N'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            reload_r <= '0;
            mode_r   <= ONE_SHOT;
            done     <= 1'b1;
            tc       <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            reload_r <= reload_n;
            mode_r   <= mode_n;
            done     <= state_n != RUN;
            tc       <= tc_n;
        end
    end

    // clear beats load, load beats the count step
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_r;
        mode_n   = mode_r;
        tc_n     = 1'b0;
        if (clear) begin
            count_n = '0;
            state_n = IDLE;
        end else if (load) begin
            count_n  = start_val;
            reload_n = start_val;
            mode_n   = timer_mode_e'(mode);
            state_n  = (start_val != '0) ? RUN : IDLE;
        end else if (term) begin
            tc_n    = 1'b1;
            count_n = (mode_r == AUTO_RELOAD) ? reload_r : '0;
            state_n = (mode_r == AUTO_RELOAD) ? RUN : DONE;
        end else if (state == RUN && enable && count != '0) begin
            count_n = count - N'(1);
        end
    end
endmodule

// File: rtl/multi_channel_down_timer.sv
// multi_channel_down_timer: NCH independent down-timers with packed vectors and a combined tc flag.
module multi_channel_down_timer #(
    parameter int N   = 8,
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   load,
    input  logic [NCH*N-1:0] start_val,
    input  logic [NCH-1:0]   mode,
    input  logic [NCH-1:0]   enable,
    input  logic [NCH-1:0]   clear,
    output logic [NCH*N-1:0] count,
    output logic [NCH-1:0]   done,
    output logic [NCH-1:0]   tc,
    output logic             any_tc
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        timer_channel #(.N(N)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .load      (load[i]),
            .start_val (start_val[i*N +: N]),
            .mode      (mode[i]),
            .enable    (enable[i]),
            .clear     (clear[i]),
            .count     (count[i*N +: N]),
            .done      (done[i]),
            .tc        (tc[i])
        );
    end

    assign any_tc = |tc;
endmodule

// File: tb/tb_multi_channel_down_timer.sv
// tb_multi_channel_down_timer: directed steps with a scoreboard of expected channel outputs.
module tb_multi_channel_down_timer;
    localparam int N = 8;
    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   load, mode, enable, clear;
    logic [NCH*N-1:0] start_val;
    logic [NCH*N-1:0] count;
    logic [NCH-1:0]   done, tc;
    logic             any_tc;

    typedef struct {
        string tag;
        int    ch;
        int    cnt;
        int    d;
        int    t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    multi_channel_down_timer #(.N(N), .NCH(NCH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .start_val (start_val),
        .mode      (mode),
        .enable    (enable),
        .clear     (clear),
        .count     (count),
        .done      (done),
        .tc        (tc),
        .any_tc    (any_tc)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic exp_ch(input string tag, input int ch, input int cnt, input int d, input int t);
        exp_t e;
        e.tag = tag;
        e.ch  = ch;
        e.cnt = cnt;
        e.d   = d;
        e.t   = t;
        q.push_back(e);
    endtask

    task automatic exp_any(input string tag, input int t);
        exp_ch(tag, -1, 0, 0, t);
    endtask

    task automatic set_ch(input int ch, input bit ld, input int sv, input bit md, input bit en, input bit cl);
        logic [N-1:0] v;
        v = sv[N-1:0];
        load[ch]              = ld;
        start_val[ch*N +: N]  = v;
        mode[ch]              = md;
        enable[ch]            = en;
        clear[ch]             = cl;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.ch < 0) begin
                cmp({e.tag, " any_tc"}, int'(any_tc), e.t);
            end else begin
                cmp({e.tag, " count"}, int'(count[e.ch*N +: N]), e.cnt);
                cmp({e.tag, " done"}, int'(done[e.ch]), e.d);
                cmp({e.tag, " tc"}, int'(tc[e.ch]), e.t);
            end
        end
    endtask

    initial begin
        int vals[4];
        int ex_any;
        reset     = 1'b1;
        load      = '1;
        mode      = 4'b1010;
        enable    = '1;
        clear     = 4'b0101;
        start_val = 32'hA5C3_7E19;
        tick();
        for (int c = 0; c < NCH; c++) exp_ch("reset", c, 0, 1, 0);
        exp_any("reset", 0);
        tick();
        reset     = 1'b0;
        load      = '0;
        mode      = '0;
        enable    = '0;
        clear     = '0;
        start_val = '0;

        set_ch(0, 1, 5, 0, 1, 0);
        exp_ch("os_load", 0, 5, 0, 0);
        tick();
        set_ch(0, 0, 0, 0, 1, 0);
        for (int k = 4; k >= 1; k--) begin
            exp_ch("os_run", 0, k, 0, 0);
            tick();
        end
        exp_ch("os_term", 0, 0, 1, 1);
        exp_any("os_term", 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            exp_ch("os_hold", 0, 0, 1, 0);
            exp_any("os_hold", 0);
            tick();
        end

        set_ch(1, 1, 3, 1, 1, 0);
        exp_ch("ar3_load", 1, 3, 0, 0);
        tick();
        set_ch(1, 0, 0, 1, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            exp_ch("ar3_run", 1, 3 - (k % 3), 0, (k % 3 == 0) ? 1 : 0);
            tick();
        end
        set_ch(1, 1, 1, 1, 1, 0);
        exp_ch("ar1_load", 1, 1, 0, 0);
        tick();
        set_ch(1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            exp_ch("ar1_run", 1, 1, 0, 1);
            exp_any("ar1_run", 1);
            tick();
        end
        set_ch(1, 0, 0, 1, 0, 0);
        exp_ch("ar1_gap", 1, 1, 0, 0);
        tick();
        set_ch(1, 0, 0, 1, 0, 1);
        exp_ch("ar1_clear", 1, 0, 1, 0);
        tick();
        set_ch(1, 0, 0, 0, 0, 0);

        set_ch(2, 1, 4, 0, 0, 0);
        exp_ch("gap_load", 2, 4, 0, 0);
        tick();
        for (int k = 1; k <= 7; k++) begin
            set_ch(2, 0, 0, 0, (k % 2 == 1), 0);
            exp_ch("gap_run", 2, (k == 7) ? 0 : 4 - (k + 1) / 2, (k == 7) ? 1 : 0, (k == 7) ? 1 : 0);
            tick();
        end
        set_ch(2, 1, 4, 0, 1, 0);
        exp_ch("clr_load", 2, 4, 0, 0);
        tick();
        set_ch(2, 0, 0, 0, 1, 0);
        exp_ch("clr_run", 2, 3, 0, 0);
        tick();
        set_ch(2, 0, 0, 0, 1, 1);
        exp_ch("clr_mid", 2, 0, 1, 0);
        tick();
        set_ch(2, 0, 0, 0, 1, 0);
        exp_ch("clr_idle", 2, 0, 1, 0);
        tick();

        set_ch(3, 1, 1, 1, 1, 0);
        exp_ch("clr_tc_load", 3, 1, 0, 0);
        tick();
        set_ch(3, 0, 0, 1, 1, 0);
        exp_ch("clr_tc_pulse", 3, 1, 0, 1);
        tick();
        set_ch(3, 0, 0, 1, 1, 1);
        exp_ch("clr_tc_after", 3, 0, 1, 0);
        exp_any("clr_tc_after", 0);
        tick();
        set_ch(3, 0, 0, 0, 0, 0);

        set_ch(0, 1, 2, 0, 1, 0);
        exp_ch("done_reload", 0, 2, 0, 0);
        tick();
        set_ch(0, 0, 0, 0, 1, 0);
        exp_ch("col_pre", 0, 1, 0, 0);
        tick();
        set_ch(0, 1, 7, 0, 1, 0);
        exp_ch("col_load7", 0, 7, 0, 0);
        exp_any("col_load7", 0);
        tick();
        set_ch(0, 1, 0, 0, 1, 0);
        exp_ch("load0_a", 0, 0, 1, 0);
        tick();
        exp_ch("load0_b", 0, 0, 1, 0);
        tick();

        vals = '{2, 3, 4, 5};
        for (int c = 0; c < NCH; c++) set_ch(c, 1, vals[c], 0, 1, 0);
        tick();
        for (int c = 0; c < NCH; c++) set_ch(c, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            ex_any = 0;
            for (int c = 0; c < NCH; c++) begin
                exp_ch("indep", c, (vals[c] - k > 0) ? vals[c] - k : 0,
                       (k >= vals[c]) ? 1 : 0, (k == vals[c]) ? 1 : 0);
                if (k == vals[c]) ex_any = 1;
            end
            exp_any("indep", ex_any);
            tick();
        end

        set_ch(0, 1, 1, 1, 1, 0);
        tick();
        set_ch(0, 0, 0, 1, 1, 0);
        exp_ch("rst_tc_pulse", 0, 1, 0, 1);
        tick();
        reset = 1'b1;
        for (int c = 0; c < NCH; c++) exp_ch("rst_tc_after", c, 0, 1, 0);
        exp_any("rst_tc_after", 0);
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_channel_down_timer.md
# multi_channel_down_timer

- Parametrised, multi-channel successor to the single-channel set-start down-counter.
- Each of NCH independent channels loads a programmable start value, counts down on its own enable, and flags terminal count.
- Each channel runs in one-shot or auto-reload mode, reports a registered done level and a one-cycle terminal-count pulse.
- Sits between control logic and the sequencing/timeout logic that consumes countdown events.

## Interface
Parameters:
- N, 8, counter width per channel (N >= 2).
- NCH, 4, number of independent channels (NCH >= 1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  NCH  per-channel load strobe.
- start_val  in  NCH*N  per-channel start value; channel i occupies bits [i*N +: N].
- mode  in  NCH  per-channel mode, sampled on load: 0 = one-shot, 1 = auto-reload.
- enable  in  NCH  per-channel count enable.
- clear  in  NCH  per-channel abort to idle.
- count  out  NCH*N  current count per channel, same packing as start_val.
- done  out  NCH  level; 1 when the channel is not running.
- tc  out  NCH  one-cycle terminal-count pulse.
- any_tc  out  1  OR of all tc bits.

## Operation
- Each channel has three states: IDLE, RUN and DONE. Each channel also holds internal registers reload_r (N bits) and mode_r.
- Reset values, all channels: state IDLE, count 0, reload_r 0, mode_r 0, done 1, tc 0, any_tc 0.
- Per-channel priority each cycle: reset > clear > load > count step.
- clear:
  - count becomes 0, state becomes IDLE, done is 1, tc is 0.
  - reload_r and mode_r are retained.
- load:
  - count and reload_r capture start_val; mode_r captures mode.
  - If start_val is nonzero, the state becomes RUN with done 0.
  - If start_val is 0, the state becomes IDLE with done 1 and no tc.
  - load is accepted in any state, including mid-count, and restarts the channel.
- RUN with enable = 1 and count > 1: count decrements by 1.
- RUN with enable = 1 and count == 1 (terminal step):
  - tc = 1 for exactly the next cycle.
  - One-shot: count becomes 0, state becomes DONE, done becomes 1.
  - Auto-reload: count becomes reload_r, state stays RUN, done stays 0.
- RUN with enable = 0: count holds and tc is 0.
- IDLE and DONE: enable is ignored and count holds. Only load leaves these states.
- A load coincident with a terminal step wins: no tc, and the new value is captured.
- Arithmetic is unsigned N-bit. There is no wrap below 0; decrement never occurs at count 0.
- Channels are fully independent; there is no cross-channel interaction except any_tc.

## Timing
- count, done and tc are registered; there is no combinational path from any input to them.
- any_tc is combinational from the tc registers only.
- Latency: load in cycle t gives count = start_val in cycle t+1.
- One-shot with value V and enable held high from t+1:
  - count runs V, V-1, …, 1 over cycles t+1 … t+V.
  - count reads 0 at t+1+V, with tc high only at t+1+V and done high from t+1+V.
- Auto-reload with value V: tc pulses once every V enabled cycles.
  - With V = 1, tc is high on every enabled cycle and count stays 1.
- Gaps in enable stretch the period cycle-for-cycle; a terminal step only happens on an enabled cycle.
- reset or clear asserted during a tc cycle: tc is 0 in the following cycle.

## Structure
- Shared package timer_pkg:
  - enum timer_state_e {IDLE, RUN, DONE};
  - enum timer_mode_e {ONE_SHOT = 0, AUTO_RELOAD = 1};
  - a channel slicing helper or localparam conventions for the i*N packing.
- Sub-module timer_channel, parametrised by N, implements one channel (state, count, reload_r, mode_r, done, tc).
- The top level instantiates NCH copies via generate, packs and unpacks the vectors, and ORs the tc bits into any_tc.

## Test plan
- Reset: assert reset for 2 cycles with arbitrary inputs.
  - Required: all count = 0, done = all 1s, tc = 0, any_tc = 0.
- One-shot, N=8, channel 0:
  - Stimulus: load 5 with enable high.
  - Required: count reads 5, 4, 3, 2, 1, 0; tc is a single pulse on the cycle count reads 0; done rises on that same cycle; count holds 0 afterwards.
- Auto-reload, channel 1:
  - Stimulus: load 3 with enable high for 10 cycles.
  - Required: count reads 3, 2, 1, 3, 2, 1, …; tc is high on each cycle count returns to 3; done stays 0.
  - Repeat with value 1: tc is high every cycle.
- Enable gaps and clear, channel 2:
  - Stimulus: load 4, toggle enable 1/0.
  - Required: the terminal step occurs after 4 enabled cycles.
  - Stimulus: clear mid-count.
  - Required: count = 0, done = 1, no tc.
- Collisions:
  - load 7 in the same cycle as a terminal step: no tc, count = 7.
  - load 0: done stays 1, no tc.
  - load in DONE: restarts the channel.
- Independence, NCH=4:
  - Stimulus: load values 2, 3, 4, 5 simultaneously with enable high.
  - Required: tc on channel i occurs at cycle t+1+start_val; any_tc is high on 4 separate cycles.
